// File: rtl/seg_display_scan.sv
// seg_display_scan: four-digit multiplexed seven-segment driver with frame-synchronous shadow register.
module seg_display_scan #(
  parameter int SCAN_DIV = 25000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result,
  input  logic        hold,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = 20;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          tick;
  logic [3:0]    nib;
  logic          z1, z2, z3, blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'ha: hex_seg = 7'b0001000;
      4'hb: hex_seg = 7'b0000011;
      4'hc: hex_seg = 7'b1000110;
      4'hd: hex_seg = 7'b0100001;
      4'he: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction
  assign tick = cnt == CW'(SCAN_DIV - 1);
  // Shadow only reloads between frames so a frame never mixes two results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      an     <= 4'b1111;
      seg    <= 7'b1111111;
      dp     <= 1'b1;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      idx    <= tick ? idx + 2'd1 : idx;
      shadow <= (tick && idx == 2'd3 && !hold) ? result : shadow;
      an     <= an_nxt;
      seg    <= seg_nxt;
      dp     <= 1'b1;
    end
  end
  always_comb begin
    nib     = shadow[{idx, 2'b00} +: 4];
    z3      = shadow[15:12] == 4'h0;
    z2      = z3 && shadow[11:8] == 4'h0;
    z1      = z2 && shadow[7:4] == 4'h0;
    blank   = BLANK_LZ && (idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0);
    an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_nxt = blank ? 7'b1111111 : hex_seg(nib);
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: three parameterisations checked against a cycle-count reference model plus directed tables.
module tb_seg_display_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] result = 16'h0;
  logic        hold = 1'b0;
  logic [3:0]  an_o [3];
  logic [6:0]  seg_o [3];
  logic        dp_o [3];
  int total = 0, bad = 0;
  int dv [3] = '{4, 4, 1};
  bit bl [3] = '{1'b0, 1'b1, 1'b1};
  int n [3];
  logic [15:0] sh [3];
  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  always #5 clk = ~clk;
  seg_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u0 (.clk(clk), .reset(reset), .result(result), .hold(hold), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]));
  seg_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u1 (.clk(clk), .reset(reset), .result(result), .hold(hold), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]));
  seg_display_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u2 (.clk(clk), .reset(reset), .result(result), .hold(hold), .an(an_o[2]), .seg(seg_o[2]), .dp(dp_o[2]));
  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  function automatic logic [10:0] ref_out(input int d, input bit blz, input int cyc, input logic [15:0] s);
    int i;
    logic [3:0] nb;
    i = (cyc / d) % 4;
    nb = s[4*i +: 4];
    if (i > 0 && blz && (s >> (4 * i)) == 16'h0) return {4'b1111, 7'b1111111};
    return {~(4'b0001 << i), segtab[nb]};
  endfunction
  // Model: slot = cycles-since-reset / SCAN_DIV; the shadow reloads each time that count reaches a multiple of 4*SCAN_DIV.
  always begin
    logic [10:0] exp [3];
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (!reset) begin
        exp[j] = {4'b1111, 7'b1111111};
        n[j] = 0;
        sh[j] = 16'h0;
      end else begin
        exp[j] = ref_out(dv[j], bl[j], n[j], sh[j]);
        n[j]++;
        if (n[j] % (4 * dv[j]) == 0 && !hold) sh[j] = result;
      end
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("model_u%0d", j), {an_o[j], seg_o[j]}, exp[j]);
      check($sformatf("dp_u%0d", j), {10'h0, dp_o[j]}, 11'h1);
      check($sformatf("an_single_u%0d", j), 11'($countones(~an_o[j]) <= 1), 11'h1);
    end
  end
  task automatic run(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    run(1);
    reset = 1'b1;
  endtask
  typedef struct {
    logic [15:0] res;
    int          u;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;
  vec_t tbl [10];
  initial begin
    tbl[0] = '{16'h1234, 0, 0, 4'b1110, 7'b0011001};
    tbl[1] = '{16'h1234, 0, 1, 4'b1101, 7'b0110000};
    tbl[2] = '{16'h1234, 0, 2, 4'b1011, 7'b0100100};
    tbl[3] = '{16'h1234, 0, 3, 4'b0111, 7'b1111001};
    tbl[4] = '{16'h0005, 1, 0, 4'b1110, 7'b0010010};
    tbl[5] = '{16'h0005, 1, 1, 4'b1111, 7'b1111111};
    tbl[6] = '{16'h0005, 1, 3, 4'b1111, 7'b1111111};
    tbl[7] = '{16'h0005, 0, 1, 4'b1101, 7'b1000000};
    tbl[8] = '{16'h00c0, 1, 1, 4'b1101, 7'b1000110};
    tbl[9] = '{16'habcd, 0, 2, 4'b1011, 7'b0000011};
    run(2);
    check("reset_state", {an_o[0], seg_o[0]}, {4'b1111, 7'b1111111});
    reset = 1'b1;
    run(1);
    check("first_after_reset", {an_o[1], seg_o[1]}, {4'b1110, 7'b1000000});
    foreach (tbl[k]) begin
      do_reset();
      result = tbl[k].res;
      run(17 + 4 * tbl[k].slot);
      check($sformatf("tbl%0d", k), {an_o[tbl[k].u], seg_o[tbl[k].u]}, {tbl[k].an, tbl[k].seg});
    end
    do_reset();
    result = 16'haaaa;
    run(21);
    result = 16'hffff;
    run(4);
    check("midframe_keep_a", {an_o[0], seg_o[0]}, {4'b1011, 7'b0001000});
    run(12);
    check("nextframe_f", {an_o[0], seg_o[0]}, {4'b1101, 7'b0001110});
    do_reset();
    result = 16'h0005;
    run(17);
    result = 16'h00c0;
    hold = 1'b1;
    run(20);
    check("hold_keeps_old", {an_o[1], seg_o[1]}, {4'b1111, 7'b1111111});
    hold = 1'b0;
    run(16);
    check("hold_release_c", {an_o[1], seg_o[1]}, {4'b1101, 7'b1000110});
    do_reset();
    result = 16'h1234;
    run(10);
    do_reset();
    run(1);
    check("reset_mid_slot", {an_o[0], seg_o[0]}, {4'b1110, 7'b1000000});
    run(3);
    check("slot0_held", {7'h0, an_o[0]}, {7'h0, 4'b1110});
    run(1);
    check("slot1_after_div", {7'h0, an_o[0]}, {7'h0, 4'b1101});
    for (int c = 0; c < 3000; c++) begin
      result = 16'($urandom);
      if ($urandom_range(3) == 0) result = result & 16'h00ff;
      hold = $urandom_range(4) == 0;
      reset = $urandom_range(199) != 0;
      run(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
